alu_rr_scheduler: RTL and testbench

//  Shares one 8-bit ALU (operands data_in1/data_in2, 4-bit operation code, result data_out) between
//  NUM_REQ requesters. Round-robin arbitration, latches winner's op/operands, drives ALU, waits
//  ALU_LAT cycles, returns result to winner via valid/ready. One transaction in flight at a time.

---
 rtl/alu_rr_scheduler.sv | 135 +++++++++++++
 tb/tb_alu_rr_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one ALU among NUM_REQ requesters; one transaction in flight.
// Optional macro ALU_PRIO_EN: requester 0 always wins arbitration when it is requesting.
module alu_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int OP_W    = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*OP_W-1:0]    req_op,
    input  logic [NUM_REQ*DATA_W-1:0]  req_a,
    input  logic [NUM_REQ*DATA_W-1:0]  req_b,
    output logic [DATA_W-1:0]          alu_in1,
    output logic [DATA_W-1:0]          alu_in2,
    output logic [OP_W-1:0]            alu_op,
    input  logic [DATA_W-1:0]          alu_out,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [IDX_W-1:0]  ptr_q;
    logic [LAT_W-1:0]  lat_cnt_q;
    logic [IDX_W-1:0]  winner;
    logic              found;
    logic              accept;
    logic              lat_done;

    // Search starts just after the last winner and wraps, so the last winner ranks lowest.
    always_comb begin
        logic [IDX_W-1:0] idx;
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = IDX_W'((32'(ptr_q) + off) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
`ifdef ALU_PRIO_EN
        if (req_valid[0]) begin
            found  = 1'b1;
            winner = '0;
        end
`else
`endif
    end

    assign lat_done = (lat_cnt_q == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                // Ready is masked during reset so no grant is ever advertised while rst_n is low.
                if (found && rst_n) begin
                    req_ready = NUM_REQ'(1) << winner;
                    accept    = 1'b1;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                if (lat_done) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q     <= IDX_W'(NUM_REQ - 1);
            lat_cnt_q <= '0;
            alu_in1   <= '0;
            alu_in2   <= '0;
            alu_op    <= '0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            if (accept) begin
                alu_in1   <= req_a[winner*DATA_W +: DATA_W];
                alu_in2   <= req_b[winner*DATA_W +: DATA_W];
                alu_op    <= req_op[winner*OP_W +: OP_W];
                rsp_id    <= winner;
                ptr_q     <= winner;
                lat_cnt_q <= LAT_W'(ALU_LAT - 1);
            end
            if (state_q == EXEC) begin
                if (lat_done) begin
                    rsp_data <= alu_out;
                end else begin
                    lat_cnt_q <= lat_cnt_q - 1'b1;
                end
            end
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Scoreboard bench for alu_rr_scheduler with an XOR ALU stub (alu_out = alu_in1 ^ alu_in2).
// Expected results are queued at grant time; a negedge monitor pops them on each response handshake.
module tb_alu_rr_scheduler;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int OP_W    = 4;

`ifdef ALU_PRIO_EN
    localparam logic [1:0] BP_ID = 2'd0;
`else
    localparam logic [1:0] BP_ID = 2'd1;
`endif

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*OP_W-1:0]   req_op;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [DATA_W-1:0]         alu_in1;
    logic [DATA_W-1:0]         alu_in2;
    logic [OP_W-1:0]           alu_op;
    logic [DATA_W-1:0]         alu_out;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [1:0]                rsp_id;
    logic [DATA_W-1:0]         rsp_data;
    logic                      busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t exp_q[$];

    // Hand-computed XOR results per requester: 11^22, CF^B0, F0^0F, 55^55.
    logic [7:0] exp_data [4] = '{8'h33, 8'h7F, 8'hFF, 8'h00};
`ifdef ALU_PRIO_EN
    logic [1:0] rr_order [5] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
    logic [1:0] rr_order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif

    alu_rr_scheduler #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .OP_W    (OP_W),
        .ALU_LAT (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    assign alu_out = alu_in1 ^ alu_in2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", {30'd0, rsp_id}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_id", {30'd0, rsp_id}, {30'd0, e.id});
                check("rsp_data", {24'd0, rsp_data}, {24'd0, e.data});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  g;
        int  last;
        bit  seen;

        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        req_a     = {8'h55, 8'hF0, 8'hCF, 8'h11};
        req_b     = {8'h55, 8'h0F, 8'hB0, 8'h22};
        req_op    = {4'h7, 4'h5, 4'h3, 4'h1};

        // Reset with every requester asking
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {28'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_alu_in1", {24'd0, alu_in1}, 32'd0);
        check("rst_alu_in2", {24'd0, alu_in2}, 32'd0);
        check("rst_alu_op", {28'd0, alu_op}, 32'd0);
        check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);

        // Single op from requester 1
        @(posedge clk); #1;
        rst_n     = 1'b1;
        req_valid = 4'b0010;
        @(negedge clk);
        check("single_grant", {28'd0, req_ready}, 32'b0010);
        exp_q.push_back('{id: 2'd1, data: 8'h7F});
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(negedge clk);
        check("single_alu_in1", {24'd0, alu_in1}, 32'hCF);
        check("single_alu_in2", {24'd0, alu_in2}, 32'hB0);
        check("single_alu_op", {28'd0, alu_op}, 32'h3);
        check("single_busy_exec", {31'd0, busy}, 32'd1);
        check("single_no_early_rsp", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        check("single_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        @(negedge clk);
        check("single_busy_low", {31'd0, busy}, 32'd0);
        check("single_alu_hold", {24'd0, alu_in1}, 32'hCF);

        // Round-robin from reset with all requesters held
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        g    = 0;
        last = 0;
        for (int c = 0; c < 25 && g < 5; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                check("rr_grant", {28'd0, req_ready}, 32'd1 << rr_order[g]);
                if (g > 0) check("rr_spacing", cyc - last, 3);
                last = cyc;
                exp_q.push_back('{id: rr_order[g], data: exp_data[rr_order[g]]});
                g++;
            end
        end
        if (g < 5) check("rr_grant_count", g, 5);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        repeat (4) @(posedge clk);
        #1;

        // Backpressure with every requester still asking
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_grant", {28'd0, req_ready}, 32'd1 << BP_ID);
        exp_q.push_back('{id: BP_ID, data: exp_data[BP_ID]});
        @(posedge clk); #1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        check("bp_rsp_seen", {31'd0, seen}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_rsp_data", {24'd0, rsp_data}, {24'd0, exp_data[BP_ID]});
            check("bp_rsp_id", {30'd0, rsp_id}, {30'd0, BP_ID});
            check("bp_no_grant", {28'd0, req_ready}, 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req_valid = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_busy", {31'd0, busy}, 32'd0);
        check("bp_release_valid", {31'd0, rsp_valid}, 32'd0);

        // Reset during EXEC abandons the transaction
        @(posedge clk); #1;
        req_valid = 4'b0100;
        @(negedge clk);
        check("mid_grant", {28'd0, req_ready}, 32'b0100);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        rst_n     = 1'b0;
        @(negedge clk);
        check("mid_in_exec", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        @(negedge clk);
        check("mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
        check("mid_idle", {31'd0, busy}, 32'd0);
        check("mid_req0_first", {28'd0, req_ready}, 32'b0001);
        exp_q.push_back('{id: 2'd0, data: 8'h33});
        @(posedge clk); #1;
        req_valid = 4'b0000;
        repeat (5) @(negedge clk);

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
